// File: rtl/oric_ram_arbiter_if.sv
// oric_ram_arbiter_if: CPU, download and SDRAM port signals of the Oric RAM arbiter
interface oric_ram_arbiter_if;
   logic        cpu_cs;
   logic        cpu_oe;
   logic        cpu_we;
   logic [15:0] cpu_a;
   logic [7:0]  cpu_d;
   logic [7:0]  cpu_q;
   logic        cpu_valid;
   logic        dl_wr;
   logic [15:0] dl_a;
   logic [7:0]  dl_d;
   logic        dl_busy;
   logic        sdram_req;
   logic        sdram_ack;
   logic [15:0] sdram_a;
   logic [1:0]  sdram_ds;
   logic        sdram_we;
   logic [15:0] sdram_d;
   logic [15:0] sdram_q;
   modport slave (
      input  cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d, dl_wr, dl_a, dl_d, sdram_ack, sdram_q,
      output cpu_q, cpu_valid, dl_busy, sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d
   );
   modport master (
      output cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d, dl_wr, dl_a, dl_d, sdram_ack, sdram_q,
      input  cpu_q, cpu_valid, dl_busy, sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d
   );
endinterface

// File: rtl/oric_ram_arbiter.sv
// oric_ram_arbiter: shares the toggle-handshake SDRAM port between the Oric CPU bus and a download write stream
module oric_ram_arbiter #(
   parameter logic [1:0] ROM_PAGE      = 2'b11,
   parameter bit         WRITE_PROTECT = 1'b1,
   parameter int         FAIR_MAX      = 4
) (
   input logic               clk_i,
   input logic               res_n_i,
   oric_ram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {SYNC, IDLE, WAIT_CPU, WAIT_DL} state_t;
   state_t      r_state;
   logic        r_prev_rd, r_prev_wr;
   logic [15:0] r_prev_a;
   logic        r_cpu_pend, r_cpu_we;
   logic [15:0] r_cpu_a;
   logic [7:0]  r_cpu_d;
   logic        r_dl_pend, r_dl_busy;
   logic [15:0] r_dl_a;
   logic [7:0]  r_dl_d;
   logic [3:0]  r_fair;
   logic        r_req, r_sd_we, r_cpu_valid;
   logic [15:0] r_sd_a, r_sd_d;
   logic [1:0]  r_sd_ds;
   logic [7:0]  r_cpu_q;
   logic        w_rd, w_wr, w_trig, w_prot, w_cap, w_done, w_dl_load, w_dl_first;
   assign w_rd       = bus.cpu_cs & bus.cpu_oe;
   assign w_wr       = bus.cpu_cs & bus.cpu_we;
   assign w_trig     = (w_rd & ~r_prev_rd) | (w_wr & ~r_prev_wr) | (w_rd & (bus.cpu_a != r_prev_a));
   assign w_prot     = WRITE_PROTECT & w_wr & (bus.cpu_a[15:14] == ROM_PAGE);
   assign w_cap      = w_trig & ~w_prot;
   assign w_done     = bus.sdram_ack == r_req;
   assign w_dl_load  = bus.dl_wr & ~r_dl_busy;
   assign w_dl_first = r_dl_pend & ((r_fair == 4'(FAIR_MAX)) | ~r_cpu_pend);
   assign bus.cpu_q     = r_cpu_q;
   assign bus.cpu_valid = r_cpu_valid;
   assign bus.dl_busy   = r_dl_busy;
   assign bus.sdram_req = r_req;
   assign bus.sdram_a   = r_sd_a;
   assign bus.sdram_ds  = r_sd_ds;
   assign bus.sdram_we  = r_sd_we;
   assign bus.sdram_d   = r_sd_d;
   // Remember last cycle's CPU strobes and address to detect access starts
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_prev_rd <= 1'b0;
         r_prev_wr <= 1'b0;
         r_prev_a  <= 16'h0000;
      end else begin
         r_prev_rd <= w_rd;
         r_prev_wr <= w_wr;
         r_prev_a  <= bus.cpu_a;
      end
   end
   // Request slots, grant/fairness FSM and the req/ack toggle sequencer
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         r_state     <= SYNC;
         r_cpu_pend  <= 1'b0;
         r_cpu_we    <= 1'b0;
         r_cpu_a     <= 16'h0000;
         r_cpu_d     <= 8'h00;
         r_dl_pend   <= 1'b0;
         r_dl_busy   <= 1'b0;
         r_dl_a      <= 16'h0000;
         r_dl_d      <= 8'h00;
         r_fair      <= 4'd0;
         r_req       <= 1'b0;
         r_sd_we     <= 1'b0;
         r_sd_a      <= 16'h0000;
         r_sd_d      <= 16'h0000;
         r_sd_ds     <= 2'b11;
         r_cpu_q     <= 8'h00;
         r_cpu_valid <= 1'b0;
      end else begin
         r_cpu_valid <= 1'b0;
         if (w_cap) begin
            r_cpu_pend <= 1'b1;
            r_cpu_a    <= bus.cpu_a;
            r_cpu_we   <= w_wr;
            r_cpu_d    <= bus.cpu_d;
         end
         if (w_dl_load) begin
            r_dl_pend <= 1'b1;
            r_dl_busy <= 1'b1;
            r_dl_a    <= bus.dl_a;
            r_dl_d    <= bus.dl_d;
         end
         case (r_state)
            SYNC: if (w_done) r_state <= IDLE;
            IDLE: begin
               if (w_dl_first) begin
                  r_sd_a    <= r_dl_a;
                  r_sd_we   <= 1'b1;
                  r_sd_d    <= {r_dl_d, r_dl_d};
                  r_sd_ds   <= r_dl_a[0] ? 2'b10 : 2'b01;
                  r_req     <= ~r_req;
                  r_dl_pend <= 1'b0;
                  r_fair    <= 4'd0;
                  r_state   <= WAIT_DL;
               end else if (r_cpu_pend) begin
                  r_sd_a     <= r_cpu_a;
                  r_sd_we    <= r_cpu_we;
                  r_sd_d     <= {r_cpu_d, r_cpu_d};
                  r_sd_ds    <= r_cpu_we ? (r_cpu_a[0] ? 2'b10 : 2'b01) : 2'b11;
                  r_req      <= ~r_req;
                  r_cpu_pend <= w_cap;
                  r_fair     <= r_dl_pend ? r_fair + 4'd1 : 4'd0;
                  r_state    <= WAIT_CPU;
               end
            end
            WAIT_CPU: begin
               if (w_done) begin
                  if (!r_sd_we) begin
                     r_cpu_q     <= r_sd_a[0] ? bus.sdram_q[15:8] : bus.sdram_q[7:0];
                     r_cpu_valid <= 1'b1;
                  end
                  r_state <= IDLE;
               end
            end
            WAIT_DL: begin
               if (w_done) begin
                  r_dl_busy <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_oric_ram_arbiter.sv
// tb_oric_ram_arbiter: scoreboard bench for the Oric RAM arbiter with a toggle-handshake SDRAM model
module tb_oric_ram_arbiter;
   typedef struct {
      logic [15:0] a;
      logic        we;
      logic [1:0]  ds;
      logic [15:0] d;
      bit          chk_d;
   } txn_t;
   logic clk = 1'b0;
   logic res_n = 1'b0;
   logic ack = 1'b0;
   logic [15:0] q = 16'h0000;
   logic force_en = 1'b1;
   logic force_val = 1'b1;
   int lat = 0;
   int tests = 0;
   int fails = 0;
   logic prev_req = 1'b0;
   logic [15:0] mem [0:32767];
   txn_t exp_txn[$];
   logic [7:0] exp_rd[$];
   oric_ram_arbiter_if bus();
   oric_ram_arbiter dut (.clk_i(clk), .res_n_i(res_n), .bus(bus));
   assign bus.sdram_ack = ack;
   assign bus.sdram_q   = q;
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask
   task automatic push(input logic [15:0] a, input logic we, input logic [1:0] ds, input logic [15:0] d, input bit cd);
      txn_t t;
      t.a = a; t.we = we; t.ds = ds; t.d = d; t.chk_d = cd;
      exp_txn.push_back(t);
   endtask
   // SDRAM model: acknowledges a toggle three cycles after it appears
   always @(posedge clk) begin
      if (force_en) begin
         ack <= force_val;
         lat <= 0;
      end else if (bus.sdram_req != ack) begin
         if (lat == 2) begin
            ack <= bus.sdram_req;
            lat <= 0;
            q   <= mem[bus.sdram_a[15:1]];
         end else lat <= lat + 1;
      end
   end
   // Monitor: compares each issued transaction and each read return against the scoreboard
   always @(negedge clk) begin
      if (res_n && bus.sdram_req != prev_req) begin
         if (exp_txn.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_txn: got a=%h d=%h we=%b expected none", bus.sdram_a, bus.sdram_d, bus.sdram_we);
         end else begin
            txn_t t;
            t = exp_txn.pop_front();
            chk("txn_a", 32'(bus.sdram_a), 32'(t.a));
            chk("txn_we", 32'(bus.sdram_we), 32'(t.we));
            chk("txn_ds", 32'(bus.sdram_ds), 32'(t.ds));
            if (t.chk_d) chk("txn_d", 32'(bus.sdram_d), 32'(t.d));
         end
      end
      prev_req <= bus.sdram_req;
      if (res_n && bus.cpu_valid) begin
         if (exp_rd.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_valid: got cpu_q=%h expected none", bus.cpu_q);
         end else chk("cpu_q", 32'(bus.cpu_q), 32'(exp_rd.pop_front()));
      end
   end
   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = a; bus.cpu_d = d;
      @(negedge clk);
      bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
   endtask
   task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
      bus.dl_wr = 1'b1; bus.dl_a = a; bus.dl_d = d;
      @(negedge clk);
      bus.dl_wr = 1'b0;
   endtask
   task automatic wait_issue();
      logic r0;
      int n;
      r0 = bus.sdram_req;
      n = 0;
      while (bus.sdram_req == r0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         tests++; fails++;
         $display("FAIL issue_timeout: got no toggle expected toggle");
      end
   endtask
   task automatic drain();
      int n;
      n = 0;
      while ((exp_txn.size() != 0 || exp_rd.size() != 0 || bus.dl_busy || bus.sdram_ack != bus.sdram_req) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         tests++; fails++;
         $display("FAIL drain_timeout: got pending=%0d expected 0", exp_txn.size());
      end
      repeat (5) @(negedge clk);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      logic saw_toggle;
      logic r_before;
      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      mem[15'h091A] = 16'hA55A;
      mem[15'h0080] = 16'hBEEF;
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0000; bus.cpu_d = 8'h00;
      bus.dl_wr = 1'b0; bus.dl_a = 16'h0000; bus.dl_d = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_req", 32'(bus.sdram_req), 0);
      chk("rst_we", 32'(bus.sdram_we), 0);
      chk("rst_valid", 32'(bus.cpu_valid), 0);
      chk("rst_busy", 32'(bus.dl_busy), 0);
      chk("rst_a", 32'(bus.sdram_a), 0);
      chk("rst_d", 32'(bus.sdram_d), 0);
      chk("rst_q", 32'(bus.cpu_q), 0);
      chk("rst_ds", 32'(bus.sdram_ds), 32'h3);
      res_n = 1'b1;
      @(negedge clk);
      push(16'h1235, 1'b0, 2'b11, 16'h0000, 1'b0);
      exp_rd.push_back(8'hA5);
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_a = 16'h1235;
      @(negedge clk);
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      saw_toggle = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.sdram_req) saw_toggle = 1'b1;
         @(negedge clk);
      end
      chk("sync_hold", 32'(saw_toggle), 0);
      force_val = 1'b0;
      @(negedge clk);
      force_en = 1'b0;
      drain();
      push(16'h2000, 1'b1, 2'b01, 16'h3C3C, 1'b1);
      cpu_wr(16'h2000, 8'h3C);
      drain();
      r_before = bus.sdram_req;
      cpu_wr(16'hC010, 8'h99);
      repeat (20) @(negedge clk);
      chk("rom_no_toggle", 32'(bus.sdram_req), 32'(r_before));
      push(16'hC010, 1'b1, 2'b01, 16'h5A5A, 1'b1);
      dl_write(16'hC010, 8'h5A);
      drain();
      push(16'h0300, 1'b1, 2'b01, 16'h3030, 1'b1);
      push(16'h0301, 1'b1, 2'b10, 16'h3131, 1'b1);
      push(16'h0302, 1'b1, 2'b01, 16'h3232, 1'b1);
      push(16'h0303, 1'b1, 2'b10, 16'h3333, 1'b1);
      push(16'h0400, 1'b1, 2'b01, 16'h4444, 1'b1);
      push(16'h0304, 1'b1, 2'b01, 16'h3434, 1'b1);
      bus.dl_wr = 1'b1; bus.dl_a = 16'h0400; bus.dl_d = 8'h44;
      bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h0300; bus.cpu_d = 8'h30;
      @(negedge clk);
      bus.dl_wr = 1'b0; bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
      chk("dl_busy_set", 32'(bus.dl_busy), 1);
      for (int i = 1; i <= 4; i++) begin
         wait_issue();
         cpu_wr(16'h0300 + 16'(i), 8'h30 + 8'(i));
      end
      drain();
      chk("dl_busy_clear", 32'(bus.dl_busy), 0);
      push(16'h0500, 1'b1, 2'b01, 16'h1111, 1'b1);
      dl_write(16'h0500, 8'h11);
      dl_write(16'h0501, 8'h77);
      chk("dl_busy_hold", 32'(bus.dl_busy), 1);
      drain();
      push(16'h0600, 1'b1, 2'b01, 16'h2222, 1'b1);
      push(16'h0101, 1'b0, 2'b11, 16'h0000, 1'b0);
      exp_rd.push_back(8'hBE);
      dl_write(16'h0600, 8'h22);
      wait_issue();
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_a = 16'h0100;
      @(negedge clk);
      bus.cpu_a = 16'h0101;
      @(negedge clk);
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      drain();
      repeat (20) @(negedge clk);
      chk("txn_queue_left", 32'(exp_txn.size()), 0);
      chk("rd_queue_left", 32'(exp_rd.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
